// File: rtl/float_sum_sequencer.sv
// float_sum_sequencer
//   Initiator side of the float unit req/ack protocol. Accepts a stream of
//   floats, issues one add (acc + element) per element to an external float
//   adder, keeps the running sum and presents it at end-of-stream with a
//   ready/valid handshake.
//
//   Optional feature macro: FLOAT_SEQ_TIMEOUT_EN
//     When defined, an add that is not acked within TIMEOUT_CYCLES aborts the
//     sum: the partial accumulator is reported with sum_err=1, and any
//     remaining elements of the stream are drained (accepted, no req) up to
//     and including the in_last element.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid never depends on ready. req and ack are single-cycle
//   pulses with their data valid in the same cycle.
//
//   dbg_state exposes the FSM state encoding for observation.

module float_sum_sequencer #(
    parameter int float_width    = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] in_data,
    input  logic                   in_last,
    output logic                   req,
    output logic [float_width-1:0] a,
    output logic [float_width-1:0] b,
    input  logic                   ack,
    input  logic [float_width-1:0] add_out,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [float_width-1:0] sum,
    output logic [COUNT_WIDTH-1:0] sum_count,
    output logic                   sum_err,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [float_width-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [float_width-1:0] a_q, a_d;
    logic [float_width-1:0] b_q, b_d;
    logic                   last_q, last_d;
    logic [float_width-1:0] sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] sum_count_q, sum_count_d;
    logic                   timeout;
    logic                   accept;

`ifdef FLOAT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    // Last WAIT cycle of the budget with no ack in sight
    assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign sum_err = err_q;
`else
    assign timeout = 1'b0;
    assign sum_err = 1'b0;
`endif

    assign accept    = in_valid & in_ready;
    assign a         = a_q;
    assign b         = b_q;
    assign sum       = sum_q;
    assign sum_count = sum_count_q;
    assign dbg_state = state_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ack only matters while an add is outstanding (WAIT)
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ack) begin
                    state_d = last_q ? S_DONE : S_IDLE;
                end else if (timeout) begin
                    state_d = last_q ? S_DONE : S_DRAIN;
                end
            end
            S_DONE:  if (sum_ready) state_d = S_IDLE;
            S_DRAIN: if (accept && in_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        req       = 1'b0;
        sum_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = ~rst;
            S_ISSUE: req       = 1'b1;
            S_DONE:  sum_valid = 1'b1;
            S_DRAIN: in_ready  = ~rst;
            default: ;
        endcase
    end

    // Datapath next-state: operand capture, accumulation and result latching
    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        sum_d       = sum_q;
        sum_count_d = sum_count_q;
`ifdef FLOAT_SEQ_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d    = acc_q;
                    b_d    = in_data;
                    last_d = in_last;
                end
            end
            S_ISSUE: begin
`ifdef FLOAT_SEQ_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_WAIT: begin
                if (ack) begin
                    acc_d   = add_out;
                    count_d = count_q + 1'b1;
                    if (last_q) begin
                        sum_d       = add_out;
                        sum_count_d = count_q + 1'b1;
                    end
                end else begin
`ifdef FLOAT_SEQ_TIMEOUT_EN
                    timer_d = timer_q + 1'b1;
                    if (timeout) begin
                        // Partial result: the unacked element is not included
                        sum_d       = acc_q;
                        sum_count_d = count_q;
                        err_d       = 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                if (sum_ready) begin
                    acc_d   = '0;
                    count_d = '0;
`ifdef FLOAT_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            sum_q       <= '0;
            sum_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            sum_q       <= sum_d;
            sum_count_q <= sum_count_d;
        end
    end

`ifdef FLOAT_SEQ_TIMEOUT_EN
    // Ack timer and abort flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_float_sum_sequencer.sv
// Bench for float_sum_sequencer: adder model acking 4 cycles after req,
// real-arithmetic reference sums on integer-valued floats, one compare
// process at the falling edge, plus literal checks from the reference cases.

module tb_float_sum_sequencer;
  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          req;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ack;
  logic [W-1:0]  add_out;
  logic          sum_valid;
  logic          sum_ready;
  logic [W-1:0]  sum;
  logic [CW-1:0] sum_count;
  logic          sum_err;
  logic [2:0]    dbg_state;

  float_sum_sequencer #(.float_width(W), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .req(req), .a(a), .b(b),
    .ack(ack), .add_out(add_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum(sum), .sum_count(sum_count), .sum_err(sum_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Integer-valued single <-> real conversions (exact for |x| < 2^24)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // ---------------- reference model ----------------
  logic [W-1:0]  exp_a_q[$];
  logic [W-1:0]  exp_b_q[$];
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic          exp_err_q[$];
  logic [W-1:0]  a_log[$];
  real           model_acc = 0.0;
  int            model_cnt = 0;
  int            req_seen = 0;

  task automatic model_push(input logic [W-1:0] d, input logic l);
    exp_a_q.push_back(r2f(model_acc));
    exp_b_q.push_back(d);
    model_acc = model_acc + f2r(d);
    model_cnt++;
    if (l) begin
      exp_q.push_back(r2f(model_acc));
      exp_cnt_q.push_back(CW'(model_cnt));
      exp_err_q.push_back(1'b0);
      model_acc = 0.0;
      model_cnt = 0;
    end
  endtask

  // ---------------- adder model ----------------
  int           pend_t[$];
  logic [W-1:0] pend_v[$];
  bit           spur = 0;
  logic [W-1:0] spur_val = '0;
  bit           drop_next = 0;

  initial begin
    ack = 1'b0;
    add_out = '0;
    forever begin
      @(posedge clk); #1;
      ack = 1'b0;
      foreach (pend_t[i]) pend_t[i] = pend_t[i] - 1;
      if (pend_t.size() > 0 && pend_t[0] <= 0) begin
        ack = 1'b1;
        add_out = pend_v.pop_front();
        void'(pend_t.pop_front());
      end else if (spur) begin
        ack = 1'b1;
        add_out = spur_val;
        spur = 0;
      end
      if (req) begin
        if (drop_next) drop_next = 0;
        else begin
          pend_t.push_back(4);
          pend_v.push_back(r2f(f2r(a) + f2r(b)));
        end
      end
    end
  end

  // ---------------- sum consumer ----------------
  int ready_mode = 2;  // 0 random, 1 hold low, 2 always high

  initial begin
    sum_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: sum_ready = ($urandom_range(0, 2) != 0);
        1: sum_ready = 1'b0;
        default: sum_ready = 1'b1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic         prev_req = 1'b0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic [CW-1:0] prev_cnt = '0;
  logic         prev_err = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_req = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (req) begin
        req_seen++;
        a_log.push_back(a);
        check("req_single_cycle", prev_req, 1'b0);
        if (exp_a_q.size() == 0) begin
          check("req_unexpected", 1'b1, 1'b0);
        end else begin
          check("req_a", a, exp_a_q.pop_front());
          check("req_b", b, exp_b_q.pop_front());
        end
      end
      if (sum_valid) begin
        check("done_in_ready", in_ready, 1'b0);
        if (prev_hold) begin
          check("sum_stable", sum, prev_sum);
          check("sum_count_stable", sum_count, prev_cnt);
          check("sum_err_stable", sum_err, prev_err);
        end
        if (sum_ready) begin
          if (exp_q.size() == 0) begin
            check("sum_unexpected", 1'b1, 1'b0);
          end else begin
            check("sum", sum, exp_q.pop_front());
            check("sum_count", sum_count, exp_cnt_q.pop_front());
            check("sum_err", sum_err, exp_err_q.pop_front());
          end
        end
      end
      prev_req  = req;
      prev_hold = sum_valid & ~sum_ready;
      prev_sum  = sum;
      prev_cnt  = sum_count;
      prev_err  = sum_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_elem(input logic [W-1:0] d, input logic l, input bit upd);
    int  n = 0;
    bit  took = 0;
    if (upd) model_push(d, l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!took && n < 500) begin
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !sum_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_sum_lit(input string name, input logic [W-1:0] es,
                              input logic [CW-1:0] ec, input logic ee);
    int n = 0;
    @(negedge clk);
    while (!sum_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!sum_valid) check({name, "_timeout"}, 1'b0, 1'b1);
    else begin
      check({name, "_sum"}, sum, es);
      check({name, "_count"}, sum_count, ec);
      check({name, "_err"}, sum_err, ee);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    int len;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    #23;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_req", req, 1'b0);
    check("rst_a", a, 32'h0);
    check("rst_b", b, 32'h0);
    check("rst_sum_valid", sum_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_sum_count", sum_count, 16'h0);
    check("rst_sum_err", sum_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);

    // model pin: integer-valued single conversion
    check("model_pin_6", r2f(f2r(32'h3F800000) + f2r(32'h40000000) + f2r(32'h40400000)), 32'h40C00000);

    // 1: single element
    ready_mode = 2;
    send_elem(32'h3F800000, 1'b1, 1'b1);
    wait_sum_lit("t1", 32'h3F800000, 16'd1, 1'b0);
    wait_idle();

    // 2: three element stream
    r0 = req_seen;
    a_log.delete();
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b0, 1'b1);
    send_elem(32'h40400000, 1'b1, 1'b1);
    wait_sum_lit("t2", 32'h40C00000, 16'd3, 1'b0);
    wait_idle();
    check("t2_req_count", req_seen - r0, 3);
    if (a_log.size() == 3) begin
      check("t2_a0", a_log[0], 32'h0);
      check("t2_a1", a_log[1], 32'h3F800000);
      check("t2_a2", a_log[2], 32'h40400000);
    end else check("t2_a_log_size", a_log.size(), 3);

    // 3: hold sum_ready low in DONE
    ready_mode = 1;
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b1, 1'b1);
    wait_sum_lit("t3", 32'h40400000, 16'd2, 1'b0);
    r0 = req_seen;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_sum", sum, 32'h40400000);
      check("t3_hold_valid", sum_valid, 1'b1);
      check("t3_hold_in_ready", in_ready, 1'b0);
    end
    check("t3_no_req", req_seen - r0, 0);
    @(posedge clk); #1;
    ready_mode = 2;
    wait_idle();
    send_elem(32'h40000000, 1'b1, 1'b1);
    wait_sum_lit("t3b", 32'h40000000, 16'd1, 1'b0);
    wait_idle();

    // 4: reset during WAIT, late ack must be ignored
    send_elem(32'h3F800000, 1'b0, 1'b1);
    r0 = 0;
    while (!req && r0 < 50) begin
      cycles(1);
      r0++;
    end
    cycles(2);
    rst = 1'b1;
    #1;
    check("t4_in_ready", in_ready, 1'b0);
    check("t4_req", req, 1'b0);
    check("t4_a", a, 32'h0);
    check("t4_b", b, 32'h0);
    check("t4_sum_valid", sum_valid, 1'b0);
    check("t4_sum", sum, 32'h0);
    check("t4_sum_count", sum_count, 16'h0);
    check("t4_sum_err", sum_err, 1'b0);
    model_acc = 0.0;
    model_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(6);
    check("t4_pending_acks", pend_t.size(), 0);
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b1, 1'b1);
    wait_sum_lit("t4", 32'h40400000, 16'd2, 1'b0);
    wait_idle();

    // 5: spurious ack in IDLE
    spur_val = 32'h40C00000;
    spur = 1;
    cycles(3);
    check("t5_state_idle", in_ready, 1'b1);
    send_elem(32'h3F800000, 1'b1, 1'b1);
    wait_sum_lit("t5", 32'h3F800000, 16'd1, 1'b0);
    wait_idle();

`ifdef FLOAT_SEQ_TIMEOUT_EN
    // 6: adder never acks the second add
    r0 = req_seen;
    send_elem(32'h3F800000, 1'b0, 1'b1);
    wait_idle();
    drop_next = 1;
    exp_a_q.push_back(32'h3F800000);
    exp_b_q.push_back(32'h40000000);
    send_elem(32'h40000000, 1'b0, 1'b0);
    send_elem(32'h40400000, 1'b1, 1'b0);
    exp_q.push_back(32'h3F800000);
    exp_cnt_q.push_back(16'd1);
    exp_err_q.push_back(1'b1);
    model_acc = 0.0;
    model_cnt = 0;
    wait_sum_lit("t6", 32'h3F800000, 16'd1, 1'b1);
    check("t6_req_count", req_seen - r0, 2);
    wait_idle();
`endif

    // randomized streams with random consumer backpressure
    ready_mode = 0;
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 5);
      for (int e = 0; e < len; e++) begin
        cycles($urandom_range(0, 2));
        send_elem(r2f(real'($urandom_range(0, 1000))), (e == len - 1), 1'b1);
      end
    end
    ready_mode = 2;
    wait_idle();
    cycles(4);
    check("end_exp_sum_empty", exp_q.size(), 0);
    check("end_exp_req_empty", exp_a_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
